// File: rtl/rom_dl_arbiter_pkg.sv
// Shared types and defaults for the ROM download arbiter.
// Imported by the arbiter top and its reset stretcher.
package rom_dl_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_HOLD
    } arb_state_t;

    localparam logic [7:0]  ROM_INDEX_MAIN = 8'd0;
    localparam logic [16:0] ROM_SIZE_DEF   = 17'h1C000;
    localparam int          RESET_HOLD_DEF = 256;

endpackage

// File: rtl/rom_dl_arbiter_reset_stretcher.sv
// Loadable down-counter that owns core_reset.
// Set forces reset high; an expired count in HOLD releases it.
module reset_stretcher
    import rom_dl_arbiter_pkg::*;
#(
    parameter int HOLD = RESET_HOLD_DEF
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic set,
    input  logic load,
    input  logic en,
    output logic done,
    output logic core_reset
);

    localparam logic [15:0] LOAD_VAL = 16'(HOLD - 1);

    logic [15:0] cnt;

    assign done = en && (cnt == 16'd0);

    // Hold counter: reload on entry to HOLD, count down while in it
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cnt <= LOAD_VAL;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (en && (cnt != 16'd0)) begin
            cnt <= cnt - 16'd1;
        end
    end

    // core_reset: a new download always wins over an expiring count
    always_ff @(posedge clk_sys) begin
        if (reset || set) begin
            core_reset <= 1'b1;
        end else if (done) begin
            core_reset <= 1'b0;
        end
    end

endmodule

// File: rtl/rom_dl_arbiter.sv
// ROM download sequencer and shared ROM port arbiter.
// Download writes take priority over williams2 ROM reads.
module rom_dl_arbiter
    import rom_dl_arbiter_pkg::*;
#(
    parameter int                ADDR_W     = 17,
    parameter logic [ADDR_W-1:0] ROM_SIZE   = ADDR_W'(ROM_SIZE_DEF),
    parameter logic [7:0]        ROM_INDEX  = ROM_INDEX_MAIN,
    parameter int                RESET_HOLD = RESET_HOLD_DEF
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [ADDR_W-1:0] ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic              ioctl_wait,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic [7:0]        cpu_data,
    output logic              cpu_valid,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din,
    input  logic              mem_ack,
    input  logic [7:0]        mem_dout,
    output logic              core_reset,
    output logic              dl_done,
    output logic              dl_overflow
);

    arb_state_t state, state_d;

    logic rom_dl, rom_dl_q;
    logic dl_rise, dl_fall;
    logic hold_pend, from_dl;
    logic go_hold, hold_load, hold_done;
    logic capture;

    logic              buf_full;
    logic [ADDR_W-1:0] buf_addr;
    logic [7:0]        buf_data;

    logic              mem_req_d, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [7:0]        mem_din_d, cpu_data_d;
    logic              cpu_valid_d, dl_done_d;

    assign rom_dl  = ioctl_download && (ioctl_index == ROM_INDEX);
    assign dl_rise = rom_dl && !rom_dl_q;
    assign dl_fall = !rom_dl && rom_dl_q;
    assign capture = ioctl_wr && rom_dl && (ioctl_addr < ROM_SIZE);

    // A hold is owed after reset or after a download ends
    assign go_hold   = (hold_pend || dl_fall) && !rom_dl;
    assign hold_load = (state_d == ST_HOLD) && (state != ST_HOLD);

    assign ioctl_wait = buf_full;

    // Download edge detection
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            rom_dl_q <= 1'b0;
        end else begin
            rom_dl_q <= rom_dl;
        end
    end

    // Pending-hold bookkeeping; from_dl marks a hold that ends a real download
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            hold_pend <= 1'b1;
            from_dl   <= 1'b0;
        end else begin
            if (dl_rise) begin
                hold_pend <= 1'b0;
                from_dl   <= 1'b0;
            end else if (dl_fall) begin
                hold_pend <= 1'b1;
                from_dl   <= 1'b1;
            end
            if (hold_load) begin
                hold_pend <= 1'b0;
            end
        end
    end

    // One-entry write buffer fed by ioctl strobes
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            buf_full    <= 1'b0;
            buf_addr    <= '0;
            buf_data    <= 8'd0;
            dl_overflow <= 1'b0;
        end else begin
            if ((state == ST_WR) && mem_ack) begin
                buf_full <= 1'b0;
            end
            if (capture) begin
                if (buf_full) begin
                    dl_overflow <= 1'b1;
                end else begin
                    buf_full <= 1'b1;
                    buf_addr <= ioctl_addr;
                    buf_data <= ioctl_dout;
                end
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // FSM next state: write beats hold beats read
    always_comb begin
        state_d = state;
        unique case (state)
            ST_IDLE: begin
                if (buf_full) begin
                    state_d = ST_WR;
                end else if (go_hold) begin
                    state_d = ST_HOLD;
                end else if (cpu_req && !rom_dl && !core_reset) begin
                    state_d = ST_RD;
                end
            end
            ST_WR: begin
                if (mem_ack) begin
                    state_d = go_hold ? ST_HOLD : ST_IDLE;
                end
            end
            ST_RD: begin
                if (mem_ack) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (dl_rise || hold_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: next values of the registered memory/cpu signals
    always_comb begin
        mem_req_d   = (state_d == ST_WR) || (state_d == ST_RD);
        mem_we_d    = (state_d == ST_WR);
        mem_addr_d  = mem_addr;
        mem_din_d   = mem_din;
        cpu_valid_d = (state == ST_RD) && mem_ack;
        cpu_data_d  = cpu_data;
        dl_done_d   = dl_done;
        if ((state_d == ST_WR) && (state != ST_WR)) begin
            mem_addr_d = buf_addr;
            mem_din_d  = buf_data;
        end
        if ((state_d == ST_RD) && (state != ST_RD)) begin
            mem_addr_d = cpu_addr;
        end
        if (cpu_valid_d) begin
            cpu_data_d = mem_dout;
        end
        if ((state == ST_HOLD) && hold_done && !dl_rise && from_dl) begin
            dl_done_d = 1'b1;
        end
    end

    // Output registers, stable for the whole memory transaction
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= 8'd0;
            cpu_valid <= 1'b0;
            cpu_data  <= 8'd0;
            dl_done   <= 1'b0;
        end else begin
            mem_req   <= mem_req_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_din   <= mem_din_d;
            cpu_valid <= cpu_valid_d;
            cpu_data  <= cpu_data_d;
            dl_done   <= dl_done_d;
        end
    end

    reset_stretcher #(
        .HOLD(RESET_HOLD)
    ) u_stretch (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .set       (dl_rise),
        .load      (hold_load),
        .en        (state == ST_HOLD),
        .done      (hold_done),
        .core_reset(core_reset)
    );

endmodule

// File: doc/rom_dl_arbiter.md
Name: rom_dl_arbiter

Overview:
- Sequences ROM download from hps_io (ioctl_*) into the core's shared program/graphics ROM memory port.
- Arbitrates that single port between download writes and williams2 CPU/video ROM fetches.
- Holds the game core in reset while a download is in progress, and for a settling interval after it ends.
- Sits between hps_io and williams2 in the emu top, clocked by clk_sys (48 MHz).

Parameters:
- ADDR_W, 17, width of ioctl_addr, cpu_addr and mem_addr.
- ROM_SIZE, 17'h1C000, number of valid ROM bytes; download writes at or above this address are discarded.
- ROM_INDEX, 8'd0, ioctl_index value that selects the ROM download.
- RESET_HOLD, 256, clk_sys cycles core_reset stays high after the download ends (range 1..65535).

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- ioctl_download  in  1  download active
- ioctl_index  in  8  download target index
- ioctl_wr  in  1  one-cycle write strobe
- ioctl_addr  in  ADDR_W  write byte address
- ioctl_dout  in  8  write data
- ioctl_wait  out  1  stall request to hps_io
- cpu_req  in  1  read request; held high until cpu_valid
- cpu_addr  in  ADDR_W  read address; stable while cpu_req is high
- cpu_data  out  8  read data
- cpu_valid  out  1  one-cycle read-complete pulse
- mem_req  out  1  memory request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W  memory address
- mem_din  out  8  memory write data
- mem_ack  in  1  one-cycle completion pulse from memory
- mem_dout  in  8  memory read data; valid in the cycle mem_ack is high
- core_reset  out  1  reset to williams2
- dl_done  out  1  sticky: at least one ROM download has completed
- dl_overflow  out  1  sticky: an ioctl_wr was lost because the write buffer was full

Behaviour:
- Reset values: ioctl_wait=0, mem_req=0, mem_we=0, mem_addr=0, mem_din=0, cpu_valid=0, cpu_data=0, core_reset=1, dl_done=0, dl_overflow=0.
- Reset mid-operation: the FSM returns to IDLE and any in-flight request is abandoned (mem_req drops at the next edge). The hold counter reloads RESET_HOLD.
- rom_dl = ioctl_download && ioctl_index==ROM_INDEX.
- Write capture:
  - Condition: ioctl_wr && rom_dl && ioctl_addr<ROM_SIZE.
  - Latches addr/data into a 1-entry buffer and sets buffer-full.
  - ioctl_wait goes high the cycle after capture and stays high until the cycle after the write's mem_ack.
  - Out-of-range or wrong-index strobes produce no memory access and no wait.
  - A strobe that arrives while buffer-full is dropped and sets dl_overflow.
- FSM states: IDLE, WR, RD, HOLD.
  - IDLE -> WR if buffer-full (write has priority).
  - IDLE -> RD if cpu_req && !rom_dl && !core_reset.
  - WR: mem_req=1, mem_we=1, buffer address/data on mem_addr/mem_din. On mem_ack: clear buffer-full; go to HOLD if download has ended, else IDLE.
  - RD: mem_req=1, mem_we=0, mem_addr=cpu_addr. On mem_ack: cpu_data<=mem_dout, cpu_valid=1 for the next cycle, -> IDLE.
  - HOLD: entered from IDLE or WR when the download has ended (falling edge of rom_dl seen) and buffer-full is clear. Counts RESET_HOLD cycles, then -> IDLE, core_reset<=0, dl_done<=1.
- Memory handshake:
  - mem_req/mem_we/mem_addr/mem_din are registered and held stable until mem_ack.
  - mem_req is low for at least one cycle between transactions.
  - mem_ack while mem_req=0 is ignored.
- Minimum read latency: cpu_req high -> mem_req at the next edge; with mem_ack in the following cycle, cpu_valid is high 3 cycles after cpu_req.
- core_reset:
  - Set by reset or by the rising edge of rom_dl.
  - Cleared only at HOLD completion.
  - After reset with no download: HOLD runs directly, so core_reset clears RESET_HOLD cycles after reset is released.
- Read blocking: cpu_req is ignored (no cpu_valid) while core_reset=1. A read already in RD completes, then writes proceed.
- Simultaneous ioctl_wr and cpu_req in IDLE: the write wins.
- Download restart during HOLD: core_reset stays 1 and the counter reloads when rom_dl falls again.

Decomposition:
- Shared package holds:
  - the FSM state enum;
  - ROM_INDEX_MAIN;
  - the default ROM_SIZE;
  - the default RESET_HOLD.
- One sub-module, reset_stretcher: a loadable down-counter producing core_reset from set/start inputs. The FSM lives in rom_dl_arbiter.

Test Plan:
- Reset release, no download -> core_reset=1 for exactly 256 cycles then 0; dl_done=0; no mem_req.
- Download of 4 bytes, index 0, addr 0..3, data A5,5A,C3,3C, mem_ack 2 cycles after each mem_req:
  - four writes with mem_we=1 and the matching addr/data;
  - ioctl_wait high during each;
  - core_reset high throughout, low 256 cycles after ioctl_download falls;
  - dl_done=1.
- Write to addr 17'h1C000, and a write with index 1 -> no mem_req, ioctl_wait stays 0.
- cpu_req addr 17'h0003 after download, mem_dout=3C with ack 1 cycle after mem_req -> cpu_valid one cycle with cpu_data=3C.
- Second ioctl_wr while the first is waiting on ack -> dl_overflow=1; only the first write reaches memory.
- Assert reset while in WR with mem_req=1 -> next edge: mem_req=0, ioctl_wait=0, core_reset=1; a late mem_ack is ignored.
